// File: rtl/ck2ck_async_fifo_pkg.sv
// Shared types and helpers for the ck2ck dual-clock FIFO.
// Holds the status encoding, default parameters and the gray-code conversions.
package pa_Ck2CkAsyncFifo;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_EMPTY,
    ST_ACTIVE,
    ST_AFULL,
    ST_FULL,
    ST_ERROR
  } ty_FifoSt;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_SYNC_STG  = 2;
  localparam int DEF_AFULL_TH  = 12;
  localparam int DEF_AEMPTY_TH = 4;
  localparam int DEF_FWFT      = 1;

  // Widest pointer (DEPTH=1024 -> 11 bits); callers zero-extend in and cast back.
  localparam int PTR_MAX_W = 11;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/ck2ck_async_fifo_if.sv
// Producer/consumer bundle of the ck2ck FIFO; master = datapath/peripheral side, slave = FIFO.
interface ck2ck_async_fifo_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  import pa_Ck2CkAsyncFifo::*;

  logic [DATA_W-1:0] wrData;
  logic              wrPush;
  logic              wrFull;
  logic              wrAlmostFull;
  logic [ADDR_W:0]   wrLevel;
  logic              wrOverflow;
  logic              wrClrErr;
  logic              rdPop;
  logic [DATA_W-1:0] rdData;
  logic              rdValid;
  logic              rdEmpty;
  logic              rdAlmostEmpty;
  logic [ADDR_W:0]   rdLevel;
  logic              rdUnderflow;
  ty_FifoSt          status;

  modport master (
    output wrData, wrPush, wrClrErr, rdPop,
    input  wrFull, wrAlmostFull, wrLevel, wrOverflow,
           rdData, rdValid, rdEmpty, rdAlmostEmpty, rdLevel, rdUnderflow, status
  );

  modport slave (
    input  wrData, wrPush, wrClrErr, rdPop,
    output wrFull, wrAlmostFull, wrLevel, wrOverflow,
           rdData, rdValid, rdEmpty, rdAlmostEmpty, rdLevel, rdUnderflow, status
  );

endinterface

// File: rtl/ck2ck_gray_sync.sv
// Multi-flop synchroniser for a gray-coded pointer; one instance per crossing direction.
module ck2ck_gray_sync #(
  parameter int W        = 5,
  parameter int SYNC_STG = 2
) (
  input  logic         ck,
  input  logic         arst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [SYNC_STG-1:0][W-1:0] sync_pipe;

  always_ff @(posedge ck or posedge arst) begin
    if (arst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[SYNC_STG-2:0], d};
  end

  assign q = sync_pipe[SYNC_STG-1];

endmodule

// File: rtl/ck2ck_async_fifo.sv
// Dual-clock FIFO, producer on ckFast, consumer on ckSlow. Gray pointers cross via
// ck2ck_gray_sync; flags are registered from next-pointer values and always pessimistic.
module ck2ck_async_fifo
  import pa_Ck2CkAsyncFifo::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int SYNC_STG  = DEF_SYNC_STG,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  parameter int FWFT      = DEF_FWFT
) (
  input logic ckFast,
  input logic ckSlow,
  input logic arstFast,
  ck2ck_async_fifo_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // ---------------- slow-domain reset: async assert, 2-edge release
  logic [1:0] rst_s;
  logic       arstSlowSync;

  always_ff @(posedge ckSlow or posedge arstFast) begin
    if (arstFast) rst_s <= 2'b11;
    else          rst_s <= {rst_s[0], 1'b0};
  end
  assign arstSlowSync = rst_s[1];

  // ---------------- write domain
  logic [PTR_W-1:0] wr_bin, wr_gray, wr_bin_nx, wr_gray_nx, wr_lvl, wr_lvl_nx, rd_gray_f, full_cmp;
  logic             push_ok, wr_full, wr_afull, wr_ovf, clr_tgl;

  always_comb begin
    push_ok    = bus.wrPush & ~wr_full;
    wr_bin_nx  = wr_bin + PTR_W'(push_ok);
    wr_gray_nx = PTR_W'(bin2gray(PTR_MAX_W'(wr_bin_nx)));
    wr_lvl_nx  = wr_bin_nx - PTR_W'(gray2bin(PTR_MAX_W'(rd_gray_f)));
    full_cmp   = {~rd_gray_f[PTR_W-1:PTR_W-2], rd_gray_f[PTR_W-3:0]};
  end

  always_ff @(posedge ckFast or posedge arstFast) begin
    if (arstFast) begin
      wr_bin   <= '0;
      wr_gray  <= '0;
      wr_lvl   <= '0;
      wr_full  <= 1'b0;
      wr_afull <= 1'b0;
      wr_ovf   <= 1'b0;
      clr_tgl  <= 1'b0;
    end else begin
      wr_bin   <= wr_bin_nx;
      wr_gray  <= wr_gray_nx;
      wr_lvl   <= wr_lvl_nx;
      wr_full  <= (wr_gray_nx == full_cmp);
      wr_afull <= (wr_lvl_nx >= PTR_W'(AFULL_TH));
      if (bus.wrClrErr)               wr_ovf <= 1'b0;
      else if (bus.wrPush & wr_full)  wr_ovf <= 1'b1;
      if (bus.wrClrErr) clr_tgl <= ~clr_tgl;
    end
  end

  always_ff @(posedge ckFast) begin
    if (push_ok) mem[wr_bin[ADDR_W-1:0]] <= bus.wrData;
  end

  // ---------------- pointer crossings
  logic [PTR_W-1:0] rd_gray, wr_gray_s;

  ck2ck_gray_sync #(.W(PTR_W), .SYNC_STG(SYNC_STG)) u_rd2wr (
    .ck(ckFast), .arst(arstFast), .d(rd_gray), .q(rd_gray_f)
  );

  ck2ck_gray_sync #(.W(PTR_W), .SYNC_STG(SYNC_STG)) u_wr2rd (
    .ck(ckSlow), .arst(arstSlowSync), .d(wr_gray), .q(wr_gray_s)
  );

  // ---------------- read domain
  logic [PTR_W-1:0] rd_bin, rd_bin_nx, rd_gray_nx, rd_lvl, rd_lvl_nx;
  logic             pop_ok, rd_empty, rd_aempty, rd_unf;
  logic [2:0]       clr_s;
  logic             rd_clr;

  always_comb begin
    pop_ok     = bus.rdPop & ~rd_empty;
    rd_bin_nx  = rd_bin + PTR_W'(pop_ok);
    rd_gray_nx = PTR_W'(bin2gray(PTR_MAX_W'(rd_bin_nx)));
    rd_lvl_nx  = PTR_W'(gray2bin(PTR_MAX_W'(wr_gray_s))) - rd_bin_nx;
    rd_clr     = clr_s[2] ^ clr_s[1];
  end

  always_ff @(posedge ckSlow or posedge arstSlowSync) begin
    if (arstSlowSync) begin
      rd_bin    <= '0;
      rd_gray   <= '0;
      rd_lvl    <= '0;
      rd_empty  <= 1'b1;
      rd_aempty <= 1'b1;
      rd_unf    <= 1'b0;
      clr_s     <= '0;
    end else begin
      rd_bin    <= rd_bin_nx;
      rd_gray   <= rd_gray_nx;
      rd_lvl    <= rd_lvl_nx;
      rd_empty  <= (rd_gray_nx == wr_gray_s);
      rd_aempty <= (rd_lvl_nx <= PTR_W'(AEMPTY_TH));
      clr_s     <= {clr_s[1:0], clr_tgl};
      if (rd_clr)                        rd_unf <= 1'b0;
      else if (bus.rdPop & rd_empty)     rd_unf <= 1'b1;
    end
  end

  logic [DATA_W-1:0] rd_data;
  logic              rd_vld;

  generate
    if (FWFT != 0) begin : g_fwft
      // Gated so the unreset array never shows on rdData while empty.
      assign rd_data = rd_empty ? '0 : mem[rd_bin[ADDR_W-1:0]];
      assign rd_vld  = ~rd_empty;
    end else begin : g_reg
      always_ff @(posedge ckSlow or posedge arstSlowSync) begin
        if (arstSlowSync) begin
          rd_data <= '0;
          rd_vld  <= 1'b0;
        end else begin
          rd_vld <= pop_ok;
          if (pop_ok) rd_data <= mem[rd_bin[ADDR_W-1:0]];
        end
      end
    end
  endgenerate

  // ---------------- status FSM (ckFast)
  logic [1:0] unf_s;
  logic       err, err_q;
  ty_FifoSt   st, st_nx;

  assign err = wr_ovf | unf_s[1];

  // Error entry is edge-triggered: the synced underflow stays high for a few
  // cycles after wrClrErr and must not pull the FSM straight back into ST_ERROR.
  always_comb begin
    st_nx = st;
    case (st)
      ST_RESET:  st_nx = ST_EMPTY;
      ST_EMPTY:  if (wr_lvl != '0) st_nx = ST_ACTIVE;
      ST_ACTIVE: if (wr_lvl == '0) st_nx = ST_EMPTY;
                 else if (wr_afull) st_nx = ST_AFULL;
      ST_AFULL:  if (wr_full) st_nx = ST_FULL;
                 else if (!wr_afull) st_nx = ST_ACTIVE;
      ST_FULL:   if (!wr_full) st_nx = ST_AFULL;
      ST_ERROR:  if (bus.wrClrErr) st_nx = ST_EMPTY;
      default:   st_nx = ST_RESET;
    endcase
    if (st != ST_RESET && st != ST_ERROR && err && !err_q) st_nx = ST_ERROR;
  end

  always_ff @(posedge ckFast or posedge arstFast) begin
    if (arstFast) begin
      unf_s <= '0;
      err_q <= 1'b0;
      st    <= ST_RESET;
    end else begin
      unf_s <= {unf_s[0], rd_unf};
      err_q <= err;
      st    <= st_nx;
    end
  end

  assign bus.wrFull        = wr_full;
  assign bus.wrAlmostFull  = wr_afull;
  assign bus.wrLevel       = wr_lvl;
  assign bus.wrOverflow    = wr_ovf;
  assign bus.rdData        = rd_data;
  assign bus.rdValid       = rd_vld;
  assign bus.rdEmpty       = rd_empty;
  assign bus.rdAlmostEmpty = rd_aempty;
  assign bus.rdLevel       = rd_lvl;
  assign bus.rdUnderflow   = rd_unf;
  assign bus.status        = st;

endmodule

// File: tb/tb_ck2ck_async_fifo.sv
// Directed bench for ck2ck_async_fifo: one FWFT=1 and one FWFT=0 instance on shared clocks.
module tb_ck2ck_async_fifo;
  import pa_Ck2CkAsyncFifo::*;

  logic ckFast, ckSlow, arstFast;
  int   n_vec, n_err, n_sent, n_recv;
  logic [31:0] sb[$];

  ck2ck_async_fifo_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();
  ck2ck_async_fifo_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();

  ck2ck_async_fifo #(.FWFT(1)) u_dut1 (.ckFast(ckFast), .ckSlow(ckSlow), .arstFast(arstFast), .bus(bus1));
  ck2ck_async_fifo #(.FWFT(0)) u_dut0 (.ckFast(ckFast), .ckSlow(ckSlow), .arstFast(arstFast), .bus(bus0));

  initial begin ckFast = 0; forever #5 ckFast = ~ckFast; end
  initial begin ckSlow = 0; #2; forever #15 ckSlow = ~ckSlow; end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_wrFull"},   64'(bus1.wrFull),        64'd0);
    chk({p, "_wrAFull"},  64'(bus1.wrAlmostFull),  64'd0);
    chk({p, "_wrLevel"},  64'(bus1.wrLevel),       64'd0);
    chk({p, "_wrOvf"},    64'(bus1.wrOverflow),    64'd0);
    chk({p, "_rdEmpty"},  64'(bus1.rdEmpty),       64'd1);
    chk({p, "_rdAEmpty"}, 64'(bus1.rdAlmostEmpty), 64'd1);
    chk({p, "_rdLevel"},  64'(bus1.rdLevel),       64'd0);
    chk({p, "_rdUnf"},    64'(bus1.rdUnderflow),   64'd0);
    chk({p, "_rdData"},   64'(bus1.rdData),        64'd0);
    chk({p, "_status"},   64'(bus1.status),        64'(ST_RESET));
    chk({p, "_rdValid0"}, 64'(bus0.rdValid),       64'd0);
    chk({p, "_rdData0"},  64'(bus0.rdData),        64'd0);
  endtask

  task automatic clr_err();
    @(negedge ckFast); bus1.wrClrErr = 1;
    @(negedge ckFast); bus1.wrClrErr = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    n_vec = 0; n_err = 0; n_sent = 0; n_recv = 0;
    arstFast = 1;
    bus1.wrData = '0; bus1.wrPush = 0; bus1.wrClrErr = 0; bus1.rdPop = 0;
    bus0.wrData = '0; bus0.wrPush = 0; bus0.wrClrErr = 0; bus0.rdPop = 0;
    #3;
    chk_rst("rst0");
    repeat (4) @(negedge ckFast);
    #1 arstFast = 0;
    repeat (3) @(posedge ckSlow);
    #1 chk("rel_status", 64'(bus1.status), 64'(ST_EMPTY));

    // 1: fill to full, then overflow
    for (int i = 0; i < 16; i++) begin
      @(negedge ckFast); bus1.wrPush = 1; bus1.wrData = 32'(i);
    end
    @(negedge ckFast); bus1.wrPush = 0;
    chk("t1_full",    64'(bus1.wrFull),       64'd1);
    chk("t1_level",   64'(bus1.wrLevel),      64'd16);
    chk("t1_afull",   64'(bus1.wrAlmostFull), 64'd1);
    repeat (2) @(negedge ckFast);
    chk("t1_st_full", 64'(bus1.status), 64'(ST_FULL));
    @(negedge ckFast); bus1.wrPush = 1; bus1.wrData = 32'd16;
    @(negedge ckFast); bus1.wrPush = 0;
    chk("t1_ovf",     64'(bus1.wrOverflow), 64'd1);
    chk("t1_lvl_ovf", 64'(bus1.wrLevel),    64'd16);
    repeat (2) @(negedge ckFast);
    chk("t1_st_err",  64'(bus1.status), 64'(ST_ERROR));

    // 2: drain in order, then underflow
    repeat (5) @(posedge ckSlow);
    #1 chk("t2_rdlevel", 64'(bus1.rdLevel), 64'd16);
    for (int i = 0; i < 16; i++) begin
      @(negedge ckSlow);
      chk("t2_data", 64'(bus1.rdData), 64'(i));
      bus1.rdPop = 1;
    end
    @(posedge ckSlow); #1 bus1.rdPop = 0;
    chk("t2_empty", 64'(bus1.rdEmpty), 64'd1);
    @(negedge ckSlow); bus1.rdPop = 1;
    @(posedge ckSlow); #1 bus1.rdPop = 0;
    chk("t2_unf", 64'(bus1.rdUnderflow), 64'd1);
    repeat (4) @(posedge ckSlow);
    #1 chk("t2_wrfull_rel", 64'(bus1.wrFull),  64'd0);
    chk("t2_wrlevel",       64'(bus1.wrLevel), 64'd0);

    clr_err();
    repeat (12) @(posedge ckSlow);
    #1 chk("clr_unf", 64'(bus1.rdUnderflow), 64'd0);
    chk("clr_ovf",    64'(bus1.wrOverflow),  64'd0);
    chk("clr_status", 64'(bus1.status),      64'(ST_EMPTY));

    // 3: streaming with random idles on both sides
    fork
      begin
        for (int c = 0; c < 40000 && n_sent < 1000; c++) begin
          @(negedge ckFast);
          if (!bus1.wrFull && $urandom_range(0, 3) != 0) begin
            bus1.wrPush = 1; bus1.wrData = 32'(n_sent * 7 + 3);
            sb.push_back(32'(n_sent * 7 + 3));
            n_sent++;
          end else bus1.wrPush = 0;
        end
        @(posedge ckFast); #1 bus1.wrPush = 0;
      end
      begin
        for (int c = 0; c < 12000 && n_recv < 1000; c++) begin
          @(negedge ckSlow);
          if (!bus1.rdEmpty && $urandom_range(0, 2) != 0) begin
            chk("t3_data", 64'(bus1.rdData), (sb.size() != 0) ? 64'(sb.pop_front()) : 64'hDEAD_0000);
            bus1.rdPop = 1;
            n_recv++;
          end else bus1.rdPop = 0;
        end
        @(posedge ckSlow); #1 bus1.rdPop = 0;
      end
    join
    chk("t3_sent", 64'(n_sent), 64'd1000);
    chk("t3_recv", 64'(n_recv), 64'd1000);
    repeat (6) @(posedge ckSlow);
    #1 chk("t3_ovf", 64'(bus1.wrOverflow),  64'd0);
    chk("t3_unf",    64'(bus1.rdUnderflow), 64'd0);
    chk("t3_empty",  64'(bus1.rdEmpty),     64'd1);
    chk("t3_wrlvl",  64'(bus1.wrLevel),     64'd0);
    chk("t3_status", 64'(bus1.status),      64'(ST_EMPTY));

    // 4: single word latency into empty
    @(negedge ckFast); bus1.wrPush = 1; bus1.wrData = 32'h0000_0044;
    @(posedge ckFast); #1 bus1.wrPush = 0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge ckSlow); #1;
      if (!bus1.rdEmpty) begin lat = k; break; end
    end
    chk("t4_lat_le3", 64'(lat >= 1 && lat <= 3), 64'd1);
    chk("t4_data",    64'(bus1.rdData),        64'h44);
    chk("t4_rdlevel", 64'(bus1.rdLevel),       64'd1);
    chk("t4_aempty",  64'(bus1.rdAlmostEmpty), 64'd1);
    chk("t4_wrlevel", 64'(bus1.wrLevel),       64'd1);

    // 5: reset with 9 words stored while a push is in progress
    for (int i = 0; i < 8; i++) begin
      @(negedge ckFast); bus1.wrPush = 1; bus1.wrData = 32'(32'h500 + i);
    end
    @(negedge ckFast); bus1.wrPush = 1; bus1.wrData = 32'h0000_0BAD;
    chk("t5_pre_lvl", 64'(bus1.wrLevel), 64'd9);
    #3 arstFast = 1;
    #1 bus1.wrPush = 0;
    chk_rst("t5");
    repeat (3) @(negedge ckFast);
    #1 arstFast = 0;
    repeat (3) @(posedge ckSlow);
    #1 chk("t5_status", 64'(bus1.status), 64'(ST_EMPTY));
    @(negedge ckFast); bus1.wrPush = 1; bus1.wrData = 32'h00C0_FFEE;
    @(negedge ckFast); bus1.wrPush = 0;
    repeat (5) @(posedge ckSlow);
    #1 chk("t5_data", 64'(bus1.rdData),  64'h00C0_FFEE);
    chk("t5_rdlevel", 64'(bus1.rdLevel), 64'd1);
    chk("t5_wrlevel", 64'(bus1.wrLevel), 64'd1);

    // 6: registered read mode on the FWFT=0 instance
    @(negedge ckFast); bus0.wrPush = 1; bus0.wrData = 32'hA5A5_0001;
    @(negedge ckFast); bus0.wrPush = 0;
    repeat (5) @(posedge ckSlow);
    #1 chk("t6_nempty", 64'(bus0.rdEmpty), 64'd0);
    chk("t6_vld_pre",   64'(bus0.rdValid), 64'd0);
    @(negedge ckSlow); bus0.rdPop = 1;
    @(posedge ckSlow); #1 bus0.rdPop = 0;
    chk("t6_vld",   64'(bus0.rdValid), 64'd1);
    chk("t6_data",  64'(bus0.rdData),  64'hA5A5_0001);
    @(posedge ckSlow); #1;
    chk("t6_vld_off", 64'(bus0.rdValid), 64'd0);
    chk("t6_hold",    64'(bus0.rdData),  64'hA5A5_0001);
    chk("t6_empty",   64'(bus0.rdEmpty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
